// File: rtl/ceil_div_seq.sv
// ceil_div_seq -- iterative unsigned ceiling divider.
//
// Computes ceil(dividend / divisor) at run time using restoring division.
// It produces one quotient bit per clock and then rounds the floor quotient
// up when the remainder is non-zero. This is the run-time counterpart of the
// elaboration-time ceil_div constant function. Typical use is burst and beat
// count calculation in DMA and interconnect address generators.
//
// Optional build macro: CEIL_DIV_SEQ_ZERO_BYPASS_EN
//   When defined, a zero dividend with a non-zero divisor skips the
//   iteration and completes one cycle after the input handshake.
//
// Parameters:
//   Width        operand and result width in bits (2..64)
//
// Ports:
//   clk_i        clock
//   rst_ni       asynchronous reset, active low
//   in_valid_i   operand pair valid
//   in_ready_o   block can accept an operand pair (high only when idle)
//   dividend_i   unsigned dividend
//   divisor_i    unsigned divisor
//   out_valid_o  result valid; held until out_ready_i
//   out_ready_i  consumer accepts result
//   quotient_o   ceiled quotient (all ones on divide by zero)
//   remainder_o  floor-division remainder (dividend on divide by zero)
//   div_zero_o   divisor was zero; qualified by out_valid_o
module ceil_div_seq #(
  parameter int Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [Width-1:0] dividend_i,
  input  logic [Width-1:0] divisor_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] quotient_o,
  output logic [Width-1:0] remainder_o,
  output logic             div_zero_o
);

  // Iteration counter width: same rule as idx_width() in the math package
  // (ceil(log2(Width)), minimum 1). Width is at least 2, so $clog2 suffices.
  localparam int CntWidth = (Width > 1) ? $clog2(Width) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e              state_reg;
  logic [CntWidth-1:0] cnt_reg;
  logic [Width-1:0]    rem_reg;      // partial remainder
  logic [Width-1:0]    quot_reg;     // dividend shifting out, quotient shifting in
  logic [Width-1:0]    divisor_reg;

  logic [Width:0]      shifted_next;
  logic [Width:0]      trial_next;
  logic [Width-1:0]    rem_next;
  logic [Width-1:0]    quot_next;

  // One restoring step. The partial remainder is always below the divisor,
  // so the shifted value fits in Width+1 bits. The trial's MSB is its sign.
  always_comb begin
    shifted_next = {rem_reg, quot_reg[Width-1]};
    trial_next   = shifted_next - {1'b0, divisor_reg};
    rem_next     = trial_next[Width] ? shifted_next[Width-1:0] : trial_next[Width-1:0];
    quot_next    = {quot_reg[Width-2:0], ~trial_next[Width]};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      rem_reg     <= '0;
      quot_reg    <= '0;
      divisor_reg <= '0;
      in_ready_o  <= 1'b1;
      out_valid_o <= 1'b0;
      quotient_o  <= '0;
      remainder_o <= '0;
      div_zero_o  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          // in_ready_o is high throughout IDLE, so in_valid_i alone completes the handshake.
          if (in_valid_i) begin
            in_ready_o  <= 1'b0;
            divisor_reg <= divisor_i;
            if (divisor_i == '0) begin
              // A zero divisor takes precedence over the zero-dividend bypass.
              state_reg   <= DONE;
              out_valid_o <= 1'b1;
              quotient_o  <= '1;
              remainder_o <= dividend_i;
              div_zero_o  <= 1'b1;
            end
`ifdef CEIL_DIV_SEQ_ZERO_BYPASS_EN
            else if (dividend_i == '0) begin
              state_reg   <= DONE;
              out_valid_o <= 1'b1;
              quotient_o  <= '0;
              remainder_o <= '0;
              div_zero_o  <= 1'b0;
            end
`endif
            else begin
              state_reg <= CALC;
              cnt_reg   <= CntWidth'(Width - 1);
              rem_reg   <= '0;
              quot_reg  <= dividend_i;
            end
          end
        end

        CALC: begin
          rem_reg  <= rem_next;
          quot_reg <= quot_next;
          if (cnt_reg == '0) begin
            // Round up on the final step. This cannot wrap: a non-zero
            // remainder means the floor quotient is below all ones.
            state_reg   <= DONE;
            out_valid_o <= 1'b1;
            quotient_o  <= quot_next + {{(Width-1){1'b0}}, |rem_next};
            remainder_o <= rem_next;
            div_zero_o  <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end

        DONE: begin
          if (out_ready_i) begin
            state_reg   <= IDLE;
            out_valid_o <= 1'b0;
            in_ready_o  <= 1'b1;
          end
        end

        default: begin
          state_reg   <= IDLE;
          in_ready_o  <= 1'b1;
          out_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ceil_div_seq.sv
// Directed and randomised checks for ceil_div_seq at Width=32.
module tb_ceil_div_seq;

  localparam int W = 32;

  logic         clk_i;
  logic         rst_ni;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [W-1:0] dividend_i;
  logic [W-1:0] divisor_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [W-1:0] quotient_o;
  logic [W-1:0] remainder_o;
  logic         div_zero_o;

  int vectors;
  int miscompares;

  ceil_div_seq #(.Width(W)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .quotient_o  (quotient_o),
    .remainder_o (remainder_o),
    .div_zero_o  (div_zero_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic int exp_latency(input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == '0) return 1;
`ifdef CEIL_DIV_SEQ_ZERO_BYPASS_EN
    if (a == '0) return 1;
`endif
    return W + 1;
  endfunction

  // One complete transaction. stall = cycles out_ready_i is held low once
  // the result is valid, while a competing operand pair is offered.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez,
                        input int stall);
    int lat;
    @(negedge clk_i);
    check({tag, " in_ready idle"}, 64'(in_ready_o), 64'd1);
    in_valid_i  = 1'b1;
    dividend_i  = a;
    divisor_i   = b;
    out_ready_i = (stall == 0);
    @(posedge clk_i);
    @(negedge clk_i);
    in_valid_i = 1'b0;
    lat = 1;
    while (!out_valid_o && lat < 100) begin
      @(posedge clk_i);
      @(negedge clk_i);
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_latency(a, b)));
    check({tag, " quotient"}, 64'(quotient_o), 64'(eq));
    check({tag, " remainder"}, 64'(remainder_o), 64'(er));
    check({tag, " div_zero"}, 64'(div_zero_o), 64'(ez));
    for (int s = 0; s < stall; s++) begin
      in_valid_i = 1'b1;
      dividend_i = 32'd50;
      divisor_i  = 32'd5;
      check({tag, " stall out_valid"}, 64'(out_valid_o), 64'd1);
      check({tag, " stall in_ready"}, 64'(in_ready_o), 64'd0);
      check({tag, " stall quotient"}, 64'(quotient_o), 64'(eq));
      check({tag, " stall remainder"}, 64'(remainder_o), 64'(er));
      check({tag, " stall div_zero"}, 64'(div_zero_o), 64'(ez));
      @(posedge clk_i);
      @(negedge clk_i);
    end
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    out_ready_i = 1'b0;
    check({tag, " out_valid drop"}, 64'(out_valid_o), 64'd0);
    check({tag, " in_ready back"}, 64'(in_ready_o), 64'd1);
  endtask

  initial begin
    logic [W-1:0] ra, rb, rq, rr;
    logic         rz;
    int           sel;
    vectors     = 0;
    miscompares = 0;
    rst_ni      = 1'b0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    dividend_i  = '0;
    divisor_i   = '0;

    // Reset state.
    #12;
    check("reset in_ready", 64'(in_ready_o), 64'd1);
    check("reset out_valid", 64'(out_valid_o), 64'd0);
    check("reset quotient", 64'(quotient_o), 64'd0);
    check("reset remainder", 64'(remainder_o), 64'd0);
    check("reset div_zero", 64'(div_zero_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Directed vectors, expected values worked out by hand.
    run_op("100/7",      32'd100,        32'd7,  32'd15,         32'd2, 1'b0, 0);
    run_op("96/8",       32'd96,         32'd8,  32'd12,         32'd0, 1'b0, 0);
    run_op("max/1",      32'hFFFF_FFFF,  32'd1,  32'hFFFF_FFFF,  32'd0, 1'b0, 0);
    run_op("5/0",        32'd5,          32'd0,  32'hFFFF_FFFF,  32'd5, 1'b1, 0);
    run_op("0/0",        32'd0,          32'd0,  32'hFFFF_FFFF,  32'd0, 1'b1, 0);
    run_op("0/9",        32'd0,          32'd9,  32'd0,          32'd0, 1'b0, 0);
    run_op("max/2",      32'hFFFF_FFFF,  32'd2,  32'h8000_0000,  32'd1, 1'b0, 0);
    run_op("3/10",       32'd3,          32'd10, 32'd1,          32'd3, 1'b0, 0);
    run_op("1/max",      32'd1,          32'hFFFF_FFFF, 32'd1,   32'd1, 1'b0, 0);

    // Back-pressure: 10 cycles of stall with a competing request offered.
    run_op("bp 100/7",   32'd100,        32'd7,  32'd15,         32'd2, 1'b0, 10);
    run_op("bp 7/0",     32'd7,          32'd0,  32'hFFFF_FFFF,  32'd7, 1'b1, 3);

    // Reset in the middle of the iteration.
    @(negedge clk_i);
    in_valid_i = 1'b1;
    dividend_i = 32'd1000;
    divisor_i  = 32'd3;
    @(posedge clk_i);
    @(negedge clk_i);
    in_valid_i = 1'b0;
    repeat (9) @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    #1;
    check("midrst in_ready", 64'(in_ready_o), 64'd1);
    check("midrst out_valid", 64'(out_valid_o), 64'd0);
    check("midrst quotient", 64'(quotient_o), 64'd0);
    check("midrst remainder", 64'(remainder_o), 64'd0);
    check("midrst div_zero", 64'(div_zero_o), 64'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    check("midrst no output", 64'(out_valid_o), 64'd0);
    rst_ni = 1'b1;
    run_op("9/4",        32'd9,          32'd4,  32'd3,          32'd1, 1'b0, 0);

    // Randomised pairs against a (a+b-1)/b reference with random stalls.
    for (int i = 0; i < 150; i++) begin
      sel = int'($urandom_range(0, 9));
      ra  = (sel == 9) ? 32'd0 : ((sel < 3) ? W'($urandom_range(0, 1000)) : W'($urandom));
      if (sel == 0)     rb = '0;
      else if (sel < 5) rb = W'($urandom_range(1, 255));
      else              rb = W'($urandom);
      if (rb == '0) begin
        rq = '1;
        rr = ra;
        rz = 1'b1;
      end else begin
        rq = W'(({32'd0, ra} + {32'd0, rb} - 64'd1) / {32'd0, rb});
        rr = ra % rb;
        rz = 1'b0;
      end
      repeat ($urandom_range(0, 2)) @(negedge clk_i);
      run_op($sformatf("rand%0d %0h/%0h", i, ra, rb), ra, rb, rq, rr, rz,
             int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
